// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the cache memory-port arbiter.
//   arb_state_t : arbiter FSM states
//   req_id_t    : requester identity, used for the round-robin tie-break bit
package cache_arb_pkg;

  localparam int ADDR_W = 32;   // byte address width
  localparam int LINE_W = 256;  // cache-line width in bits
  localparam int CNT_W  = 32;   // performance counter width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between icache and dcache.
// One requester is granted at a time. Its request is latched and the memory
// port is driven from registers; the response is routed back in the cycle
// mem_resp arrives. Simultaneous requests are broken round-robin.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_read, i_address              icache line-read request
//   i_rdata, i_resp                icache return data / completion
//   d_read, d_write, d_address,
//   d_wdata                        dcache read / writeback request
//   d_rdata, d_resp                dcache return data / completion
//   mem_read, mem_write,
//   mem_address, mem_wdata         shared memory port (registered)
//   mem_rdata, mem_resp            shared memory port response
//   i_grant_cnt, d_grant_cnt,
//   conflict_cnt                   performance counters (wrap around)
module cache_arbiter #(
  parameter int ADDR_W = cache_arb_pkg::ADDR_W,
  parameter int LINE_W = cache_arb_pkg::LINE_W,
  parameter int CNT_W  = cache_arb_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt,
  output logic [CNT_W-1:0]  conflict_cnt
);
  import cache_arb_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t        state_q;
  req_id_t           last_grant_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic [CNT_W-1:0]  i_grant_cnt_q;
  logic [CNT_W-1:0]  d_grant_cnt_q;
  logic [CNT_W-1:0]  conflict_cnt_q;

  logic i_req;
  logic d_req;
  logic conflict;
  logic grant_i;
  logic grant_d;

  // Grant decision, only acted on in IDLE. On a tie the requester that did
  // not win the previous tie is chosen.
  always_comb begin
    i_req    = i_read;
    d_req    = d_read | d_write;
    conflict = i_req & d_req;
    grant_d  = d_req & (~i_req | (last_grant_q == REQ_I));
    grant_i  = i_req & ~grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= REQ_I;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_address_q  <= '0;
      mem_wdata_q    <= '0;
      i_grant_cnt_q  <= '0;
      d_grant_cnt_q  <= '0;
      conflict_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q       <= I_BUSY;
            mem_read_q    <= 1'b1;
            mem_write_q   <= 1'b0;
            mem_address_q <= i_address;
            i_grant_cnt_q <= i_grant_cnt_q + CNT_ONE;
          end else if (grant_d) begin
            state_q       <= D_BUSY;
            // read and write together is treated as a writeback
            mem_read_q    <= ~d_write;
            mem_write_q   <= d_write;
            mem_address_q <= d_address;
            mem_wdata_q   <= d_wdata;
            d_grant_cnt_q <= d_grant_cnt_q + CNT_ONE;
          end
          // the tie-break bit only moves when there actually was a tie
          if (conflict) begin
            conflict_cnt_q <= conflict_cnt_q + CNT_ONE;
            last_grant_q   <= grant_d ? REQ_D : REQ_I;
          end
        end
        I_BUSY, D_BUSY: begin
          // request lines are not looked at here: a dropped request still
          // runs to completion
          if (mem_resp) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  // Completion is forwarded combinationally; mem_resp in IDLE goes nowhere.
  assign i_resp  = (state_q == I_BUSY) & mem_resp;
  assign d_resp  = (state_q == D_BUSY) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_address  = mem_address_q;
  assign mem_wdata    = mem_wdata_q;
  assign i_grant_cnt  = i_grant_cnt_q;
  assign d_grant_cnt  = d_grant_cnt_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule
